// File: rtl/char_buf_pkg.sv
// Shared constants for the character buffer: FSM encoding, buffer geometry,
// and the CPU/RAM mux mode codes used by the top-level RAM owner select.
package char_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } char_buf_state_e;

  localparam int CHAR_BUF_BASE   = 1500;
  localparam int CHAR_BUF_COLS   = 12;
  localparam int CHAR_BUF_ROWS   = 9;
  localparam int CHAR_BUF_LEN    = CHAR_BUF_COLS * CHAR_BUF_ROWS;
  localparam int CHAR_BUF_ADDR_W = 12;

  // RAM mux modes; the read side only runs while the CPU side is idle
  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_WRITE = 2'd1,
    CPU_EXEC  = 2'd2
  } cpu_mode_e;

endpackage

// File: rtl/char_buffer_reader.sv
// Drains the 12x9 character buffer from data RAM and streams it out one byte
// per valid/ready transfer, with row-end and last-char flags.
//
// state | meaning
// IDLE  | waiting for start, RAM address released
// FETCH | ram_addr stable, RAM samples it this cycle
// WAIT  | ram_data valid, latch char or stop on NUL
// SEND  | char_valid held until char_ready
// FIN   | one-cycle done pulse, RAM released
module char_buffer_reader
  import char_buf_pkg::*;
#(
  parameter int BASE_ADDR   = CHAR_BUF_BASE,
  parameter int NUM_CHARS   = CHAR_BUF_LEN,
  parameter int ROW_LEN     = CHAR_BUF_COLS,
  parameter bit STOP_ON_NUL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] ram_addr,
  input  logic [31:0] ram_data,
  output logic        ram_req,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_eol,
  output logic        char_last,
  output logic        busy,
  output logic        done,
  output logic [6:0]  count
);

  localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [11:0]      BASE12   = 12'(BASE_ADDR);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [6:0]       IDX_LAST = 7'(NUM_CHARS - 1);

  if ((BASE_ADDR + NUM_CHARS - 1 > 4095) || (NUM_CHARS < 1) || (NUM_CHARS > 128)) begin : g_bad_cfg
    $error("char_buffer_reader: buffer does not fit the 12-bit address or 7-bit count");
  end

  char_buf_state_e  state, state_n;
  logic [6:0]       idx, idx_n;
  logic [COL_W-1:0] col, col_n;
  logic [6:0]       count_n;
  logic [11:0]      ram_addr_n;
  logic [7:0]       char_data_n;
  logic             char_valid_n, char_eol_n, char_last_n, ram_req_n;
  logic             xfer;
  logic             unused_ram_bits;

  assign unused_ram_bits = ^ram_data[31:8];
  assign xfer = char_valid && char_ready;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    col_n        = col;
    count_n      = count;
    ram_addr_n   = ram_addr;
    char_data_n  = char_data;
    char_valid_n = char_valid;
    char_eol_n   = char_eol;
    char_last_n  = char_last;
    ram_req_n    = ram_req;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n    = ST_FETCH;
          idx_n      = '0;
          col_n      = '0;
          count_n    = '0;
          ram_addr_n = BASE12;
          ram_req_n  = 1'b1;
        end
      end
      ST_FETCH: state_n = ST_WAIT;
      ST_WAIT: begin
        if (STOP_ON_NUL && (ram_data[7:0] == 8'h00)) begin
          state_n   = ST_FIN;
          ram_req_n = 1'b0;
        end else begin
          char_data_n  = ram_data[7:0];
          char_valid_n = 1'b1;
          char_eol_n   = (col == COL_LAST);
          char_last_n  = (idx == IDX_LAST);
          state_n      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          count_n      = count + 7'd1;
          char_valid_n = 1'b0;
          char_eol_n   = 1'b0;
          char_last_n  = 1'b0;
          if (char_last) begin
            state_n   = ST_FIN;
            ram_req_n = 1'b0;
          end else begin
            idx_n      = idx + 7'd1;
            col_n      = (col == COL_LAST) ? '0 : col + 1'b1;
            ram_addr_n = BASE12 + {5'b0, idx} + 12'd1;
            state_n    = ST_FETCH;
          end
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // abort keeps any transfer that lands on the same edge but emits nothing more
    if (abort && (state != ST_IDLE)) begin
      state_n      = ST_IDLE;
      char_valid_n = 1'b0;
      char_eol_n   = 1'b0;
      char_last_n  = 1'b0;
      ram_req_n    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      col        <= '0;
      count      <= '0;
      ram_addr   <= '0;
      char_data  <= '0;
      char_valid <= 1'b0;
      char_eol   <= 1'b0;
      char_last  <= 1'b0;
      ram_req    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      col        <= col_n;
      count      <= count_n;
      ram_addr   <= ram_addr_n;
      char_data  <= char_data_n;
      char_valid <= char_valid_n;
      char_eol   <= char_eol_n;
      char_last  <= char_last_n;
      ram_req    <= ram_req_n;
    end
  end

endmodule

// File: tb/tb_char_buffer_reader.sv
// Bench for char_buffer_reader: a queue-based model of the expected character
// stream and handshake latency, checked on every cycle, plus literal pins.
module tb_char_buffer_reader;
  import char_buf_pkg::*;

  localparam int BASE = 1500;
  localparam int NCH  = 108;

  logic        clock;
  logic        reset, start, abort, char_ready;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_req, char_valid, char_eol, char_last, busy, done;
  logic [7:0]  char_data;
  logic [6:0]  count;

  logic [31:0] mem [0:4095];

  char_buffer_reader #(
    .BASE_ADDR(BASE), .NUM_CHARS(NCH), .ROW_LEN(12), .STOP_ON_NUL(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_req(ram_req),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_eol(char_eol), .char_last(char_last), .busy(busy), .done(done),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ram_data <= mem[ram_addr];

  typedef struct {
    logic [7:0] d;
    bit         eol;
    bit         last;
  } exp_t;

  exp_t m_q[$];
  bit   m_active;
  int   m_gap, m_count;
  int   vectors, miscompares;
  int   ready_mode, stall;
  int   xfers, eol_seen, last_seen, done_seen, stall_seen, max_addr;
  logic [7:0] first_data, last_data;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
    return m_active && (m_gap == 0) && (m_q.size() > 0);
  endfunction

  function automatic bit exp_done();
    return m_active && (m_gap == 0) && (m_q.size() == 0);
  endfunction

  // advance the model across one posedge using the inputs applied at it
  task automatic model_edge();
    bit xfer, was_done, was_last;
    xfer     = exp_valid() && char_ready;
    was_done = exp_done();
    was_last = 1'b0;
    if (!reset) begin
      m_active = 1'b0; m_count = 0; m_gap = 0; m_q.delete();
    end else if (m_active) begin
      if (m_gap > 0) m_gap--;
      if (was_done) m_active = 1'b0;
      else begin
        if (xfer) begin
          m_count++;
          was_last = m_q[0].last;
          void'(m_q.pop_front());
        end
        if (abort) begin
          m_active = 1'b0; m_q.delete();
        end else if (xfer) m_gap = was_last ? 0 : 2;
      end
    end else if (start && !abort) begin
      exp_t e;
      m_active = 1'b1; m_count = 0; m_gap = 2; m_q.delete();
      for (int i = 0; i < NCH; i++) begin
        if (mem[BASE + i][7:0] == 8'h00) break;
        e.d = mem[BASE + i][7:0];
        e.eol = ((i % 12) == 11);
        e.last = (i == NCH - 1);
        m_q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    bit ev, ed, er;
    ev = exp_valid();
    ed = exp_done();
    er = m_active && !ed;
    chk("char_valid", int'(char_valid), int'(ev));
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(ed));
    chk("ram_req", int'(ram_req), int'(er));
    chk("count", int'(count), m_count);
    if (ev) begin
      chk("char_data", int'(char_data), int'(m_q[0].d));
      chk("char_eol", int'(char_eol), int'(m_q[0].eol));
      chk("char_last", int'(char_last), int'(m_q[0].last));
    end
    if (er) chk("ram_addr", int'(ram_addr), BASE + m_count);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
    case (ready_mode)
      0: char_ready = 1'b1;
      1: char_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (char_valid) begin
          if (stall < 5) begin char_ready = 1'b0; stall++; end
          else char_ready = 1'b1;
        end else begin
          stall = 0; char_ready = 1'b1;
        end
      end
    endcase
    if (reset) begin
      if (done) done_seen++;
      if (ram_req && (int'(ram_addr) > max_addr)) max_addr = int'(ram_addr);
      if (char_valid && !char_ready) stall_seen++;
      if (char_valid && char_ready) begin
        if (xfers == 0) first_data = char_data;
        xfers++;
        if (char_eol) eol_seen++;
        if (char_last) begin last_seen++; last_data = char_data; end
      end
    end
  endtask

  task automatic clr_mon();
    xfers = 0; eol_seen = 0; last_seen = 0; done_seen = 0; stall_seen = 0; max_addr = 0;
    first_data = 8'h00; last_data = 8'h00;
  endtask

  task automatic fill_alpha();
    for (int i = 0; i < NCH; i++) mem[BASE + i] = {$urandom_range(0, 65535), 8'h00, 8'(8'h41 + (i % 26))};
  endtask

  task automatic wait_idle(input int budget, input int abort_cyc);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      abort = (n == abort_cyc);
      cycle();
      n++;
    end
    abort = 1'b0;
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int n, nul_pos, exp_cnt;
    bit pulsed;
    logic [31:0] w;
    vectors = 0; miscompares = 0;
    m_active = 1'b0; m_gap = 0; m_count = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; char_ready = 1'b1;
    ready_mode = 0; stall = 0;
    clr_mon();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_char_data", int'(char_data), 0);
    chk("rst_char_valid", int'(char_valid), 0);

    // basic drain, ready held high
    fill_alpha();
    clr_mon();
    pulse_start();
    n = 1;
    while (!char_valid && (n < 10)) begin cycle(); n++; end
    chk("first_valid_latency", n, 3);
    chk("first_char", int'(char_data), 8'h41);
    wait_idle(1000, -1);
    chk("basic_xfers", xfers, 108);
    chk("basic_eol_count", eol_seen, 9);
    chk("basic_last_count", last_seen, 1);
    chk("basic_last_char", int'(last_data), 8'h44);
    chk("basic_done_pulses", done_seen, 1);
    chk("basic_count", int'(count), 108);
    cycle();

    // backpressure: 5 stalled cycles per char, plus a start while busy
    ready_mode = 2;
    clr_mon();
    pulse_start();
    n = 0; pulsed = 1'b0;
    while (busy && (n < 3000)) begin
      start = (count == 7'd50) && !pulsed;
      if (start) pulsed = 1'b1;
      cycle();
      n++;
    end
    start = 1'b0;
    chk("bp_timeout", int'(busy), 0);
    chk("bp_xfers", xfers, 108);
    chk("bp_stalls", stall_seen, 540);
    chk("bp_done_pulses", done_seen, 1);
    chk("bp_count", int'(count), 108);
    ready_mode = 0;
    cycle();

    // NUL stop after "HELLO"
    fill_alpha();
    mem[BASE + 0] = 32'h48; mem[BASE + 1] = 32'h45; mem[BASE + 2] = 32'h4C;
    mem[BASE + 3] = 32'h4C; mem[BASE + 4] = 32'h4F; mem[BASE + 5] = 32'hABCD_EF00;
    clr_mon();
    pulse_start();
    wait_idle(200, -1);
    chk("nul_xfers", xfers, 5);
    chk("nul_last_seen", last_seen, 0);
    chk("nul_done_pulses", done_seen, 1);
    chk("nul_count", int'(count), 5);
    chk("nul_max_addr", max_addr, 1505);
    cycle();

    // NUL at index 0
    mem[BASE] = 32'h0;
    pulse_start();
    n = 1;
    while (!done && (n < 10)) begin cycle(); n++; end
    chk("nul0_done_latency", n, 3);
    chk("nul0_count", int'(count), 0);
    cycle();
    chk("nul0_idle", int'(busy), 0);

    // abort during the SEND of char 40
    fill_alpha();
    clr_mon();
    pulse_start();
    n = 0;
    while (!(char_valid && (count == 7'd39)) && (n < 500)) begin cycle(); n++; end
    chk("abort_reached_char40", int'(char_valid && (count == 7'd39)), 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_count", int'(count), 40);
    chk("abort_valid", int'(char_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_done", done_seen, 0);
    pulse_start();
    chk("restart_addr", int'(ram_addr), 1500);
    wait_idle(1000, -1);
    chk("restart_count", int'(count), 108);
    cycle();

    // reset during WAIT
    pulse_start();
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("rst_wait_busy", int'(busy), 0);
    chk("rst_wait_req", int'(ram_req), 0);
    chk("rst_wait_addr", int'(ram_addr), 0);
    chk("rst_wait_data", int'(char_data), 0);
    cycle();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    cycle();
    chk("start_abort_req", int'(ram_req), 0);

    // randomized contents and ready; odd runs stop on a NUL, run 4 aborts
    for (int r = 0; r < 6; r++) begin
      ready_mode = 1;
      nul_pos = $urandom_range(0, NCH - 1);
      for (int i = 0; i < NCH; i++) begin
        w = $urandom();
        w[7:0] = 8'($urandom_range(1, 255));
        if (((r % 2) == 1) && (i == nul_pos)) w[7:0] = 8'h00;
        mem[BASE + i] = w;
      end
      exp_cnt = ((r % 2) == 1) ? nul_pos : NCH;
      clr_mon();
      pulse_start();
      wait_idle(4000, (r == 4) ? int'($urandom_range(10, 200)) : -1);
      if (r != 4) begin
        chk("rand_count", int'(count), exp_cnt);
        chk("rand_done_pulses", done_seen, 1);
      end else begin
        chk("rand_abort_no_done", done_seen, 0);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
